mem_arbiter: RTL and testbench

Single-port memory arbiter between the instruction-fetch path and the MEM-stage load/store path of the five-stage pipeline. It sequences one memory transaction at a time on a shared req/ack bus and gives the MEM stage fixed priority over fetch. It holds the bus signals stable for each transaction and returns read data and a one-cycle ack to the winning requester. It also raises per-port stall requests toward `stall_control`.

---
 rtl/mem_arbiter_pkg.sv | 27 ++
 rtl/mem_arbiter_watchdog.sv | 45 ++++
 rtl/mem_arbiter.sv | 216 +++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 366 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_arbiter_pkg
// Shared definitions for the single-port memory arbiter:
//   - arb_state_t : 2-bit FSM encoding (ARB_IDLE/ARB_IF_BUSY/ARB_MEM_BUSY/ARB_RESP)
//   - ARB_SEL_ALL : byte-enable pattern driven on fetch transactions
//   - wd_cnt_w()  : watchdog counter width (at least 8 bits)
// -----------------------------------------------------------------------------
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE     = 2'd0,
    ARB_IF_BUSY  = 2'd1,
    ARB_MEM_BUSY = 2'd2,
    ARB_RESP     = 2'd3
  } arb_state_t;

  localparam logic [3:0] ARB_SEL_ALL = 4'hF;

  // The counter must be able to represent the limit and is never narrower
  // than 8 bits.
  function automatic int unsigned wd_cnt_w(input int unsigned limit);
    int unsigned w;
    w = $clog2(limit + 1);
    return (w > 8) ? w : 8;
  endfunction

endpackage

// File: rtl/mem_arbiter_watchdog.sv
// -----------------------------------------------------------------------------
// arb_watchdog
// Cycle counter with compare used to abandon a bus transaction that never
// receives bus_ack. Only built when MEM_ARB_WATCHDOG_EN is defined.
// Ports:
//   clk       : clock
//   rst       : asynchronous active-low reset
//   i_clr     : hold the count at zero (arbiter not in a BUSY state)
//   i_en      : count this cycle (BUSY and no bus_ack)
//   o_timeout : this edge would bring the count to TIMEOUT
// -----------------------------------------------------------------------------
`ifdef MEM_ARB_WATCHDOG_EN
module arb_watchdog
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_timeout
);

  localparam int unsigned CNT_W = wd_cnt_w(TIMEOUT);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // TIMEOUT ack-less BUSY cycles have elapsed once the count is TIMEOUT-1
  // and this cycle is also ack-less.
  assign o_timeout = i_en && (r_cnt == LAST_CNT);

endmodule
`endif

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Single-port memory arbiter between instruction fetch (IF) and the MEM-stage
// load/store path. One transaction at a time on a shared req/ack bus; the MEM
// port has fixed priority over fetch.
//
// Optional feature: define MEM_ARB_WATCHDOG_EN to build the bus watchdog
// (arb_watchdog). Without it the arbiter waits for bus_ack indefinitely and
// bus_err is tied low.
//
// Handshake: a requester raises *_req with its fields and holds req high
// until it sees its one-cycle *_ack; read data is valid in that ack cycle and
// is held until the next completion on the same port. On the bus side,
// bus_req and the bus fields stay constant from the grant edge until bus_ack
// is sampled high; bus_rdata is only meaningful together with bus_ack.
//
// Ports:
//   clk, rst                 : clock, asynchronous active-low reset
//   if_req/if_addr           : fetch request, PC
//   if_rdata/if_ack          : fetched instruction, completion pulse
//   mem_req/we/sel/addr/wdata: load/store request
//   mem_rdata/mem_ack        : load data, completion pulse
//   bus_req/we/sel/addr/wdata: shared bus request (registered)
//   bus_rdata/bus_ack        : shared bus response
//   stallreq_if/stallreq_mem : per-port waiting indication (combinational)
//   bus_err                  : sticky watchdog error
//   dbg_state                : current FSM state
// -----------------------------------------------------------------------------
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ack,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [3:0]        mem_sel,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_ack,
  output logic              bus_req,
  output logic              bus_we,
  output logic [3:0]        bus_sel,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic [DATA_W-1:0] bus_rdata,
  input  logic              bus_ack,
  output logic              stallreq_if,
  output logic              stallreq_mem,
  output logic              bus_err,
  output logic [1:0]        dbg_state
);

  arb_state_t r_state;
  arb_state_t w_next;

  logic              w_busy;
  logic              w_timeout;
  logic              w_done;

  logic              r_bus_req;
  logic              r_bus_we;
  logic [3:0]        r_bus_sel;
  logic [ADDR_W-1:0] r_bus_addr;
  logic [DATA_W-1:0] r_bus_wdata;
  logic              r_if_ack;
  logic              r_mem_ack;
  logic [DATA_W-1:0] r_if_rdata;
  logic [DATA_W-1:0] r_mem_rdata;

  assign w_busy = (r_state == ARB_IF_BUSY) || (r_state == ARB_MEM_BUSY);

`ifdef MEM_ARB_WATCHDOG_EN
  logic r_bus_err;

  arb_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk       (clk),
    .rst       (rst),
    .i_clr     (!w_busy),
    .i_en      (w_busy && !bus_ack),
    .o_timeout (w_timeout)
  );

  // w_timeout is already masked by bus_ack, so a late ack wins the race and
  // never raises the error.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_bus_err <= 1'b0;
    end else if (w_timeout) begin
      r_bus_err <= 1'b1;
    end
  end

  assign bus_err = r_bus_err;
`else
  assign w_timeout = 1'b0;
  assign bus_err   = 1'b0;

  // TIMEOUT only sizes the watchdog; it stays on the interface so both builds
  // share one parameter list.
  if (TIMEOUT == 0) begin : g_timeout_unused
  end
`endif

  // A transaction ends on a sampled bus_ack or on a watchdog expiry.
  assign w_done = bus_ack || w_timeout;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ARB_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      ARB_IDLE: begin
        if (mem_req) begin
          w_next = ARB_MEM_BUSY;
        end else if (if_req) begin
          w_next = ARB_IF_BUSY;
        end
      end
      ARB_IF_BUSY,
      ARB_MEM_BUSY: begin
        if (w_done) begin
          w_next = ARB_RESP;
        end
      end
      ARB_RESP: w_next = ARB_IDLE;
      default:  w_next = ARB_IDLE;
    endcase
  end

  // Registered bus fields, acks and read data. The bus fields are only
  // written on the IDLE->BUSY grant, which keeps them stable for the whole
  // transaction regardless of what the requesters do meanwhile.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_bus_req   <= 1'b0;
      r_bus_we    <= 1'b0;
      r_bus_sel   <= 4'h0;
      r_bus_addr  <= '0;
      r_bus_wdata <= '0;
      r_if_ack    <= 1'b0;
      r_mem_ack   <= 1'b0;
      r_if_rdata  <= '0;
      r_mem_rdata <= '0;
    end else begin
      r_if_ack  <= 1'b0;
      r_mem_ack <= 1'b0;
      case (r_state)
        ARB_IDLE: begin
          if (mem_req) begin
            r_bus_req   <= 1'b1;
            r_bus_we    <= mem_we;
            r_bus_sel   <= mem_sel;
            r_bus_addr  <= mem_addr;
            r_bus_wdata <= mem_wdata;
          end else if (if_req) begin
            r_bus_req   <= 1'b1;
            r_bus_we    <= 1'b0;
            r_bus_sel   <= ARB_SEL_ALL;
            r_bus_addr  <= if_addr;
            r_bus_wdata <= '0;
          end
        end
        ARB_IF_BUSY: begin
          if (w_done) begin
            r_bus_req  <= 1'b0;
            r_if_ack   <= 1'b1;
            r_if_rdata <= bus_ack ? bus_rdata : '0;
          end
        end
        ARB_MEM_BUSY: begin
          if (w_done) begin
            r_bus_req   <= 1'b0;
            r_mem_ack   <= 1'b1;
            r_mem_rdata <= bus_ack ? bus_rdata : '0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Output logic
  assign bus_req      = r_bus_req;
  assign bus_we       = r_bus_we;
  assign bus_sel      = r_bus_sel;
  assign bus_addr     = r_bus_addr;
  assign bus_wdata    = r_bus_wdata;
  assign if_ack       = r_if_ack;
  assign mem_ack      = r_mem_ack;
  assign if_rdata     = r_if_rdata;
  assign mem_rdata    = r_mem_rdata;
  assign stallreq_if  = if_req  & ~r_if_ack;
  assign stallreq_mem = mem_req & ~r_mem_ack;
  assign dbg_state    = r_state;

endmodule

// File: tb/tb_mem_arbiter.sv
`timescale 1ns/1ps
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          if_req, if_ack, mem_req, mem_we, mem_ack;
  logic [AW-1:0] if_addr, mem_addr, bus_addr;
  logic [DW-1:0] if_rdata, mem_rdata, mem_wdata, bus_wdata, bus_rdata;
  logic [3:0]    mem_sel, bus_sel;
  logic          bus_req, bus_we, bus_ack, stallreq_if, stallreq_mem, bus_err;
  logic [1:0]    dbg_state;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .mem_req(mem_req), .mem_we(mem_we), .mem_sel(mem_sel), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .bus_req(bus_req), .bus_we(bus_we), .bus_sel(bus_sel), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack),
    .stallreq_if(stallreq_if), .stallreq_mem(stallreq_mem), .bus_err(bus_err),
    .dbg_state(dbg_state)
  );

  // ---------------- scoreboard bookkeeping ----------------
  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_state"},     dbg_state, ARB_IDLE);
    chk({tag, "_bus_req"},   bus_req, 0);
    chk({tag, "_bus_we"},    bus_we, 0);
    chk({tag, "_bus_sel"},   bus_sel, 0);
    chk({tag, "_bus_addr"},  bus_addr, 0);
    chk({tag, "_bus_wdata"}, bus_wdata, 0);
    chk({tag, "_if_ack"},    if_ack, 0);
    chk({tag, "_mem_ack"},   mem_ack, 0);
    chk({tag, "_if_rdata"},  if_rdata, 0);
    chk({tag, "_mem_rdata"}, mem_rdata, 0);
    chk({tag, "_bus_err"},   bus_err, 0);
  endtask

  // ---------------- table-driven single transactions ----------------
  typedef struct {
    logic        is_mem;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          delay;   // bus_ack-low cycles after the grant
    logic        e_we;
    logic [3:0]  e_sel;
  } vec_t;

  vec_t vecs[5];

  task automatic do_txn(input vec_t v, input int idx);
    string n;
    n = $sformatf("vec%0d", idx);
    if (v.is_mem) begin
      mem_req = 1; mem_we = v.we; mem_sel = v.sel; mem_addr = v.addr; mem_wdata = v.wdata;
    end else begin
      if_req = 1; if_addr = v.addr;
    end
    tick();
    chk({n, "_bus_req"},  bus_req, 1);
    chk({n, "_bus_addr"}, bus_addr, v.addr);
    chk({n, "_bus_we"},   bus_we, v.e_we);
    chk({n, "_bus_sel"},  bus_sel, v.e_sel);
    if (v.is_mem) chk({n, "_bus_wdata"}, bus_wdata, v.wdata);
    chk({n, "_stall"}, v.is_mem ? stallreq_mem : stallreq_if, 1);
    for (int d = 0; d < v.delay; d++) begin
      tick();
      chk({n, "_no_early_ack"}, {if_ack, mem_ack}, 0);
      chk({n, "_req_held"}, bus_req, 1);
    end
    bus_ack = 1; bus_rdata = v.rdata;
    tick();
    bus_ack = 0; bus_rdata = 32'hBAD0_BAD0;
    chk({n, "_ack"},       v.is_mem ? mem_ack : if_ack, 1);
    chk({n, "_other_ack"}, v.is_mem ? if_ack : mem_ack, 0);
    chk({n, "_rdata"},     v.is_mem ? mem_rdata : if_rdata, v.rdata);
    chk({n, "_stall_drop"}, v.is_mem ? stallreq_mem : stallreq_if, 0);
    chk({n, "_bus_req_clr"}, bus_req, 0);
    if (v.is_mem) mem_req = 0; else if_req = 0;
    tick();
    chk({n, "_ack_1cyc"},  v.is_mem ? mem_ack : if_ack, 0);
    chk({n, "_rdata_hold"}, v.is_mem ? mem_rdata : if_rdata, v.rdata);
  endtask

  // ---------------- randomized phase: reference model state ----------------
  logic          p_if, p_mem, p_ack, p_mem_we;
  logic [31:0]   p_rd, p_if_addr, p_mem_addr, p_mem_wdata;
  logic [3:0]    p_mem_sel;
  logic          m_busy, m_cool, m_port, m_we;
  logic [31:0]   m_addr, m_wdata, m_if_rd, m_mem_rd;
  logic [3:0]    m_sel;
  int            m_wait, n_done;
  logic [DW:0]   exp_q[$];   // {port (1 = MEM), read data}
  logic [DW:0]   e;
  logic          e_ifa, e_mema;

  // ---------------- main sequence ----------------
  initial begin
    rst = 0;
    if_req = 0; if_addr = '0;
    mem_req = 0; mem_we = 0; mem_sel = '0; mem_addr = '0; mem_wdata = '0;
    bus_ack = 0; bus_rdata = '0;

    vecs[0] = '{1'b0, 1'b0, 4'h0, 32'h0000_0100, 32'h0,         32'h2402_0005, 0, 1'b0, 4'hF};
    vecs[1] = '{1'b1, 1'b0, 4'hF, 32'h0000_1000, 32'h0,         32'h1111_2222, 1, 1'b0, 4'hF};
    vecs[2] = '{1'b1, 1'b1, 4'h3, 32'h0000_2004, 32'hDEAD_BEEF, 32'h5A5A_5A5A, 0, 1'b1, 4'h3};
    vecs[3] = '{1'b0, 1'b0, 4'h0, 32'h0000_0104, 32'h0,         32'h8C43_0000, 3, 1'b0, 4'hF};
    vecs[4] = '{1'b1, 1'b1, 4'h8, 32'h0000_3FFC, 32'h0102_0304, 32'h0000_0077, 2, 1'b1, 4'h8};

    repeat (2) @(posedge clk);
    #1;
    chk_reset_vals("reset");
    rst = 1;
    tick();

    for (int i = 0; i < 5; i++) do_txn(vecs[i], i);

    // Simultaneous requests: store wins, fetch follows three cycles later.
    if_req = 1; if_addr = 32'h100;
    mem_req = 1; mem_we = 1; mem_addr = 32'h2000; mem_wdata = 32'hCAFE_F00D; mem_sel = 4'b0011;
    tick();
    chk("sim_store_first_addr", bus_addr, 32'h2000);
    chk("sim_store_we",   bus_we, 1);
    chk("sim_store_sel",  bus_sel, 4'b0011);
    chk("sim_store_wdata", bus_wdata, 32'hCAFE_F00D);
    chk("sim_stall_if_0", stallreq_if, 1);
    bus_ack = 1; bus_rdata = 32'h0;
    tick();
    bus_ack = 0;
    chk("sim_mem_ack", mem_ack, 1);
    chk("sim_if_no_ack", if_ack, 0);
    chk("sim_stall_if_1", stallreq_if, 1);
    mem_req = 0; mem_we = 0;
    tick();
    chk("sim_resp_idle_bus", bus_req, 0);
    chk("sim_stall_if_2", stallreq_if, 1);
    tick();
    chk("sim_fetch_granted", bus_req, 1);
    chk("sim_fetch_addr", bus_addr, 32'h100);
    chk("sim_fetch_we", bus_we, 0);
    chk("sim_fetch_sel", bus_sel, 4'hF);
    chk("sim_stall_if_3", stallreq_if, 1);
    bus_ack = 1; bus_rdata = 32'h0000_0013;
    tick();
    bus_ack = 0;
    chk("sim_if_ack", if_ack, 1);
    chk("sim_if_rdata", if_rdata, 32'h0000_0013);
    if_req = 0;
    tick();

    // Stability: requester address changes while the bus waits five cycles.
    mem_req = 1; mem_we = 0; mem_sel = 4'hF; mem_addr = 32'h2000;
    tick();
    chk("stab_addr_latched", bus_addr, 32'h2000);
    mem_addr = 32'hFFFF;
    for (int d = 0; d < 5; d++) begin
      tick();
      chk("stab_addr_held", bus_addr, 32'h2000);
      chk("stab_stall_mem", stallreq_mem, 1);
    end
    bus_ack = 1; bus_rdata = 32'h1234_5678;
    tick();
    bus_ack = 0;
    chk("stab_mem_ack", mem_ack, 1);
    chk("stab_mem_rdata", mem_rdata, 32'h1234_5678);
    mem_req = 0;
    tick();

    // Stray bus_ack while idle.
    bus_ack = 1; bus_rdata = 32'hFFFF_FFFF;
    tick();
    bus_ack = 0;
    chk("stray_state", dbg_state, ARB_IDLE);
    chk("stray_acks", {if_ack, mem_ack}, 0);
    chk("stray_bus_req", bus_req, 0);
    chk("stray_if_rdata", if_rdata, 32'h0000_0013);
    tick();
    chk("stray_acks_later", {if_ack, mem_ack}, 0);

`ifdef MEM_ARB_WATCHDOG_EN
    // bus_ack on the timeout cycle wins.
    mem_req = 1; mem_addr = 32'h4000;
    tick();
    for (int d = 1; d < TO; d++) begin
      tick();
      chk("wd_race_wait_ack", mem_ack, 0);
      chk("wd_race_req_held", bus_req, 1);
    end
    bus_ack = 1; bus_rdata = 32'h0000_600D;
    tick();
    bus_ack = 0;
    chk("wd_race_ack", mem_ack, 1);
    chk("wd_race_rdata", mem_rdata, 32'h0000_600D);
    chk("wd_race_no_err", bus_err, 0);
    mem_req = 0;
    tick();
    // No bus_ack at all: abandoned after TIMEOUT BUSY cycles.
    mem_req = 1; mem_addr = 32'h4100;
    tick();
    for (int d = 1; d < TO; d++) begin
      tick();
      chk("wd_wait_ack", mem_ack, 0);
      chk("wd_wait_err", bus_err, 0);
    end
    tick();
    chk("wd_timeout_ack", mem_ack, 1);
    chk("wd_timeout_rdata", mem_rdata, 0);
    chk("wd_timeout_err", bus_err, 1);
    chk("wd_timeout_bus_req", bus_req, 0);
    mem_req = 0;
    tick();
    chk("wd_ack_1cyc", mem_ack, 0);
    chk("wd_err_sticky", bus_err, 1);
    tick();
    chk("wd_err_sticky2", bus_err, 1);
`else
    // No watchdog: the arbiter keeps waiting and never flags an error.
    mem_req = 1; mem_addr = 32'h4000;
    tick();
    for (int d = 0; d < 20; d++) begin
      tick();
      chk("nowd_no_ack", mem_ack, 0);
      chk("nowd_req_held", bus_req, 1);
      chk("nowd_stall", stallreq_mem, 1);
      chk("nowd_err", bus_err, 0);
    end
    bus_ack = 1; bus_rdata = 32'h0000_600D;
    tick();
    bus_ack = 0;
    chk("nowd_late_ack", mem_ack, 1);
    chk("nowd_late_rdata", mem_rdata, 32'h0000_600D);
    mem_req = 0;
    tick();
`endif

    // Reset in the middle of a fetch.
    if_req = 1; if_addr = 32'h200;
    tick();
    chk("rstmid_busy", bus_req, 1);
    rst = 0;
    #1;
    chk_reset_vals("rstmid");
    if_req = 0;
    tick();
    tick();
    rst = 1;
    for (int d = 0; d < 4; d++) begin
      tick();
      chk("rstmid_no_ack", {if_ack, mem_ack}, 0);
      chk("rstmid_no_req", bus_req, 0);
    end

    // Randomized traffic against a transaction-level reference model.
    m_busy = 0; m_cool = 0; m_port = 0; m_we = 0; m_sel = '0;
    m_addr = '0; m_wdata = '0; m_if_rd = '0; m_mem_rd = '0; m_wait = 0; n_done = 0;
    for (int cyc = 0; cyc < 800; cyc++) begin
      p_if = if_req; p_mem = mem_req; p_ack = bus_ack; p_rd = bus_rdata;
      p_if_addr = if_addr; p_mem_addr = mem_addr; p_mem_we = mem_we;
      p_mem_sel = mem_sel; p_mem_wdata = mem_wdata;
      tick();
      // One transaction in flight; after it ends one cycle ignores requests,
      // then MEM beats IF at the next grant.
      if (m_busy) begin
        if (p_ack) begin
          exp_q.push_back({m_port, p_rd});
          m_busy = 0; m_cool = 1;
        end else begin
          m_wait++;
        end
      end else if (m_cool) begin
        m_cool = 0;
      end else if (p_mem) begin
        m_busy = 1; m_port = 1; m_addr = p_mem_addr; m_we = p_mem_we;
        m_sel = p_mem_sel; m_wdata = p_mem_wdata; m_wait = 0;
      end else if (p_if) begin
        m_busy = 1; m_port = 0; m_addr = p_if_addr; m_we = 0;
        m_sel = 4'hF; m_wdata = '0; m_wait = 0;
      end
      e_ifa = 0; e_mema = 0;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_done++;
        if (e[DW]) begin e_mema = 1; m_mem_rd = e[DW-1:0]; end
        else begin e_ifa = 1; m_if_rd = e[DW-1:0]; end
      end
      chk("rnd_bus_req", bus_req, m_busy);
      if (m_busy) begin
        chk("rnd_bus_addr", bus_addr, m_addr);
        chk("rnd_bus_we", bus_we, m_we);
        chk("rnd_bus_sel", bus_sel, m_sel);
        if (m_port) chk("rnd_bus_wdata", bus_wdata, m_wdata);
      end
      chk("rnd_if_ack", if_ack, e_ifa);
      chk("rnd_mem_ack", mem_ack, e_mema);
      chk("rnd_if_rdata", if_rdata, m_if_rd);
      chk("rnd_mem_rdata", mem_rdata, m_mem_rd);
      chk("rnd_stall_if", stallreq_if, if_req & ~e_ifa);
      chk("rnd_stall_mem", stallreq_mem, mem_req & ~e_mema);
      chk("rnd_bus_err", bus_err, 0);

      // Bus slave: answers within four BUSY cycles, sometimes acks stray.
      bus_ack = 0;
      if (m_busy) begin
        if ($urandom_range(0, 2) == 0 || m_wait >= 3) begin
          bus_ack = 1; bus_rdata = $urandom;
        end
      end else if ($urandom_range(0, 7) == 0) begin
        bus_ack = 1; bus_rdata = $urandom;
      end
      // Requesters: hold req until ack, address may wander while waiting.
      if (e_ifa) if_req = 0;
      else if (!if_req) begin
        if ($urandom_range(0, 2) == 0) begin if_req = 1; if_addr = $urandom; end
      end else if ($urandom_range(0, 3) == 0) if_addr = $urandom;
      if (e_mema) mem_req = 0;
      else if (!mem_req) begin
        if ($urandom_range(0, 2) == 0) begin
          mem_req = 1; mem_addr = $urandom; mem_we = 1'($urandom_range(0, 1));
          mem_sel = 4'($urandom_range(0, 15)); mem_wdata = $urandom;
        end
      end else if ($urandom_range(0, 3) == 0) mem_addr = $urandom;
    end
    chk("rnd_enough_completions", n_done > 50, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Safety net in case a wait never returns.
  initial begin
    #200000;
    failures++;
    $display("FAIL global_timeout: got simulation time %0t expected end before it", $time);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
